// File: rtl/cam_stream_tx.sv
// Synthetic OV7670-style byte stream source (VSYNC/HREF/YUV422 data) for bench and bring-up builds.
// Optional feature: define CAM_TX_FRAME_STAMP_EN to stamp the frame count into the first two Y bytes of each frame.
module cam_stream_tx #(
    parameter int unsigned IMAGE_WIDTH  = 640,
    parameter int unsigned IMAGE_HEIGHT = 480,
    parameter int unsigned FRAME_WIDTH  = 784,
    parameter int unsigned FRAME_HEIGHT = 510,
    parameter int unsigned VS_LINES     = 3,
    parameter int unsigned V_START      = 17
) (
    input  logic        clock,
    input  logic        n_rst,
    input  logic        in_enable,
    input  logic [1:0]  in_mode,
    input  logic [7:0]  in_level,
    output logic        out_vs,
    output logic        out_href,
    output logic [7:0]  out_data,
    output logic        out_busy,
    output logic [15:0] out_frame_cnt
);

    localparam int unsigned LINE_BYTES = 2 * FRAME_WIDTH;
    localparam int unsigned HREF_BYTES = 2 * IMAGE_WIDTH;
    localparam int unsigned V_END      = V_START + IMAGE_HEIGHT;
    localparam int unsigned BW         = $clog2(LINE_BYTES);
    localparam int unsigned VW         = $clog2(FRAME_HEIGHT);

    localparam logic [BW-1:0] B_LAST  = BW'(LINE_BYTES - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(FRAME_HEIGHT - 1);
    localparam logic [VW-1:0] V_FIRST = VW'(V_START);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [BW-1:0]  b;
    logic [BW-1:0]  b_n;
    logic [VW-1:0]  v;
    logic [VW-1:0]  v_n;
    logic [1:0]     mode;
    logic [1:0]     mode_n;
    logic [7:0]     level;
    logic [7:0]     level_n;
    logic [15:0]    cnt_n;
    logic           vs_n;
    logic           href_n;
    logic [7:0]     data_n;
    logic           busy_n;
    logic [7:0]     h8;
    logic [7:0]     a8;
    logic [7:0]     luma;

    // Registers hold the slot currently on the outputs; outputs are computed from the next slot.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            state         <= IDLE;
            b             <= '0;
            v             <= '0;
            mode          <= '0;
            level         <= '0;
            out_frame_cnt <= '0;
            out_vs        <= 1'b0;
            out_href      <= 1'b0;
            out_data      <= 8'h00;
            out_busy      <= 1'b0;
        end else begin
            state         <= state_n;
            b             <= b_n;
            v             <= v_n;
            mode          <= mode_n;
            level         <= level_n;
            out_frame_cnt <= cnt_n;
            out_vs        <= vs_n;
            out_href      <= href_n;
            out_data      <= data_n;
            out_busy      <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        b_n     = b;
        v_n     = v;
        mode_n  = mode;
        level_n = level;
        cnt_n   = out_frame_cnt;
        vs_n    = 1'b0;
        href_n  = 1'b0;
        data_n  = 8'h00;
        busy_n  = 1'b0;
        luma    = 8'h00;

        // Slot sequencing; in_enable only matters when idle or at the last slot of a frame.
        unique case (state)
            IDLE: begin
                b_n = '0;
                v_n = '0;
                if (in_enable) begin
                    state_n = RUN;
                    mode_n  = in_mode;
                    level_n = in_level;
                end
            end
            RUN: begin
                if (b == B_LAST) begin
                    b_n = '0;
                    if (v == V_LAST) begin
                        v_n = '0;
                        if (in_enable) begin
                            mode_n  = in_mode;
                            level_n = in_level;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        v_n = v + VW'(1);
                    end
                end else begin
                    b_n = b + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Frame counter advances on the edge that drives the final slot.
        if (state_n == RUN && b_n == B_LAST && v_n == V_LAST) begin
            cnt_n = out_frame_cnt + 16'd1;
        end

        h8 = 8'(b_n >> 1);
        a8 = 8'(v_n - V_FIRST);

        unique case (mode_n)
            2'd0:    luma = h8;
            2'd1:    luma = a8;
            2'd2:    luma = (h8[5] ^ a8[5]) ? 8'hFF : 8'h00;
            default: luma = level_n;
        endcase

`ifdef CAM_TX_FRAME_STAMP_EN
        // Count is still the pre-increment value on the first active line.
        if (v_n == V_FIRST) begin
            if (b_n == BW'(1)) begin
                luma = out_frame_cnt[15:8];
            end else if (b_n == BW'(3)) begin
                luma = out_frame_cnt[7:0];
            end
        end
`endif

        if (state_n == RUN) begin
            busy_n = 1'b1;
            vs_n   = (32'(v_n) < VS_LINES);
            href_n = (32'(v_n) >= V_START) && (32'(v_n) < V_END) && (32'(b_n) < HREF_BYTES);
            if (href_n) begin
                data_n = b_n[0] ? luma : 8'h80;
            end
        end
    end

endmodule

// File: tb/tb_cam_stream_tx.sv
// Directed bench for cam_stream_tx on an 8x4 image inside a 12x8 frame (24 cycles/line, 192 cycles/frame).
module tb_cam_stream_tx;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int FRM_W  = 12;
    localparam int FRM_H  = 8;
    localparam int VS_L   = 1;
    localparam int V_ST   = 2;
    localparam int LINE   = 2 * FRM_W;
    localparam int FRAME  = LINE * FRM_H;

    logic        clock;
    logic        n_rst;
    logic        in_enable;
    logic [1:0]  in_mode;
    logic [7:0]  in_level;
    logic        out_vs;
    logic        out_href;
    logic [7:0]  out_data;
    logic        out_busy;
    logic [15:0] out_frame_cnt;

    int checks = 0;
    int errors = 0;

    cam_stream_tx #(
        .IMAGE_WIDTH  (IMG_W),
        .IMAGE_HEIGHT (IMG_H),
        .FRAME_WIDTH  (FRM_W),
        .FRAME_HEIGHT (FRM_H),
        .VS_LINES     (VS_L),
        .V_START      (V_ST)
    ) dut (
        .clock         (clock),
        .n_rst         (n_rst),
        .in_enable     (in_enable),
        .in_mode       (in_mode),
        .in_level      (in_level),
        .out_vs        (out_vs),
        .out_href      (out_href),
        .out_data      (out_data),
        .out_busy      (out_busy),
        .out_frame_cnt (out_frame_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] level;
        int         cyc;
        logic       vs;
        logic       href;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vs"},   16'(out_vs),   16'd0);
        chk({tag, "_href"}, 16'(out_href), 16'd0);
        chk({tag, "_data"}, 16'(out_data), 16'd0);
        chk({tag, "_busy"}, 16'(out_busy), 16'd0);
        chk({tag, "_cnt"},  out_frame_cnt, 16'd0);
    endtask

    task automatic do_reset();
        n_rst     = 1'b0;
        in_enable = 1'b0;
        step();
        n_rst = 1'b1;
    endtask

    // Leaves the bench in cycle 1 of the first frame.
    task automatic start(input logic [1:0] mode, input logic [7:0] level);
        in_mode   = mode;
        in_level  = level;
        in_enable = 1'b1;
        step();
    endtask

    function automatic logic [7:0] model_data(input int slot, input logic [1:0] mode,
                                              input logic [7:0] level, input logic [15:0] cnt);
        int v;
        int b;
        int h;
        int a;
        logic [7:0] y;
        v = slot / LINE;
        b = slot % LINE;
        if (v < V_ST || v >= V_ST + IMG_H || b >= 2 * IMG_W) return 8'h00;
        if (b % 2 == 0) return 8'h80;
        h = b / 2;
        a = v - V_ST;
        case (mode)
            2'd0:    y = 8'(h);
            2'd1:    y = 8'(a);
            2'd2:    y = ((((h >> 5) ^ (a >> 5)) & 1) != 0) ? 8'hFF : 8'h00;
            default: y = level;
        endcase
`ifdef CAM_TX_FRAME_STAMP_EN
        if (a == 0 && h == 0) y = cnt[15:8];
        else if (a == 0 && h == 1) y = cnt[7:0];
`else
        if (cnt == 16'hFFFF && slot < 0) y = 8'h00;
`endif
        return y;
    endfunction

    // Checks every slot of one frame, starting in its cycle 1 and ending in its cycle 192.
    task automatic sweep(input logic [1:0] mode, input logic [7:0] level, input logic [15:0] cnt,
                         input int sw_cyc, output int vs_cnt, output int href_cnt);
        int v;
        int b;
        vs_cnt   = 0;
        href_cnt = 0;
        for (int c = 1; c <= FRAME; c++) begin
            v = (c - 1) / LINE;
            b = (c - 1) % LINE;
            chk($sformatf("sweep_vs@%0d", c), 16'(out_vs), 16'(v < VS_L));
            chk($sformatf("sweep_href@%0d", c), 16'(out_href),
                16'(v >= V_ST && v < V_ST + IMG_H && b < 2 * IMG_W));
            chk($sformatf("sweep_data@%0d", c), 16'(out_data), 16'(model_data(c - 1, mode, level, cnt)));
            chk($sformatf("sweep_busy@%0d", c), 16'(out_busy), 16'd1);
            if (c < FRAME) chk($sformatf("sweep_cnt@%0d", c), out_frame_cnt, cnt);
            if (out_vs) vs_cnt++;
            if (out_href) href_cnt++;
            if (c == sw_cyc) in_mode = 2'd0;
            if (c < FRAME) step();
        end
    endtask

    initial begin
        int vsc;
        int hc;
        n_rst     = 1'b0;
        in_enable = 1'b0;
        in_mode   = 2'd0;
        in_level  = 8'h00;

        //          mode  level  cyc  vs    href  data
        vecs[0]  = '{2'd0, 8'h00, 1,   1'b1, 1'b0, 8'h00};
        vecs[1]  = '{2'd0, 8'h00, 24,  1'b1, 1'b0, 8'h00};
        vecs[2]  = '{2'd0, 8'h00, 25,  1'b0, 1'b0, 8'h00};
        vecs[3]  = '{2'd0, 8'h00, 49,  1'b0, 1'b1, 8'h80};
        vecs[4]  = '{2'd0, 8'h00, 74,  1'b0, 1'b1, 8'h00};
        vecs[5]  = '{2'd0, 8'h00, 76,  1'b0, 1'b1, 8'h01};
        vecs[6]  = '{2'd0, 8'h00, 88,  1'b0, 1'b1, 8'h07};
        vecs[7]  = '{2'd0, 8'h00, 89,  1'b0, 1'b0, 8'h00};
        vecs[8]  = '{2'd0, 8'h00, 136, 1'b0, 1'b1, 8'h07};
        vecs[9]  = '{2'd0, 8'h00, 146, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{2'd1, 8'h00, 74,  1'b0, 1'b1, 8'h01};
        vecs[11] = '{2'd1, 8'h00, 122, 1'b0, 1'b1, 8'h03};
        vecs[12] = '{2'd1, 8'h00, 121, 1'b0, 1'b1, 8'h80};
        vecs[13] = '{2'd2, 8'h00, 86,  1'b0, 1'b1, 8'h00};
        vecs[14] = '{2'd3, 8'hA5, 100, 1'b0, 1'b1, 8'hA5};
        vecs[15] = '{2'd3, 8'h3C, 74,  1'b0, 1'b1, 8'h3C};

        // Reset held, then idle with enable low.
        repeat (5) begin
            step();
            chk_idle("reset");
        end
        n_rst = 1'b1;
        repeat (50) begin
            step();
            chk_idle("idle");
        end

        for (int i = 0; i < 16; i++) begin
            do_reset();
            start(vecs[i].mode, vecs[i].level);
            repeat (vecs[i].cyc - 1) step();
            chk($sformatf("vec%0d_vs", i),   16'(out_vs),   16'(vecs[i].vs));
            chk($sformatf("vec%0d_href", i), 16'(out_href), 16'(vecs[i].href));
            chk($sformatf("vec%0d_data", i), 16'(out_data), 16'(vecs[i].data));
            chk($sformatf("vec%0d_busy", i), 16'(out_busy), 16'd1);
        end

        // Full-frame geometry in mode 0 and seamless start of the next frame.
        do_reset();
        start(2'd0, 8'h00);
        sweep(2'd0, 8'h00, 16'd0, 0, vsc, hc);
        chk("geom_vs_cycles", 16'(vsc), 16'(LINE * VS_L));
        chk("geom_href_cycles", 16'(hc), 16'(2 * IMG_W * IMG_H));
        step();
        chk("geom_f2_vs", 16'(out_vs), 16'd1);
        chk("geom_f2_busy", 16'(out_busy), 16'd1);
        chk("geom_cnt", out_frame_cnt, 16'd1);

        // Mode/level latched at frame start; mid-frame mode change applies to frame 2 only.
        do_reset();
        start(2'd3, 8'h5A);
        sweep(2'd3, 8'h5A, 16'd0, 30, vsc, hc);
        step();
        sweep(2'd0, 8'h5A, 16'd1, 0, vsc, hc);

        // Drop enable mid-frame; the frame still completes.
        do_reset();
        start(2'd0, 8'h00);
        repeat (99) step();
        in_enable = 1'b0;
        repeat (92) step();
        chk("stop_busy_last", 16'(out_busy), 16'd1);
        step();
        chk("stop_busy_after", 16'(out_busy), 16'd0);
        chk("stop_vs_after", 16'(out_vs), 16'd0);
        chk("stop_cnt", out_frame_cnt, 16'd1);
        step();
        chk("stop_still_idle", 16'(out_busy), 16'd0);

        // Reset in the middle of frame 2 clears everything; restart at slot (0,0).
        do_reset();
        start(2'd1, 8'h00);
        repeat (FRAME + 59) step();
        chk("rst_pre_cnt", out_frame_cnt, 16'd1);
        n_rst = 1'b0;
        step();
        chk_idle("rst_mid");
        n_rst = 1'b1;
        step();
        chk("rst_restart_vs", 16'(out_vs), 16'd1);
        chk("rst_restart_busy", 16'(out_busy), 16'd1);
        repeat (73) step();
        chk("rst_restart_data", 16'(out_data), 16'h01);

`ifdef CAM_TX_FRAME_STAMP_EN
        // Frame 4 carries count 3 in the first two Y bytes of line 2.
        do_reset();
        start(2'd3, 8'h5A);
        repeat (3 * FRAME + 48) step();
        chk("stamp_c0", 16'(out_data), 16'h80);
        step();
        chk("stamp_hi", 16'(out_data), 16'h00);
        step();
        step();
        chk("stamp_lo", 16'(out_data), 16'h03);
        step();
        step();
        chk("stamp_after", 16'(out_data), 16'h5A);
        chk("stamp_cnt", out_frame_cnt, 16'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
